// File: rtl/hash_table_requester_if.sv
// Handshake bundle between the hash table requester, its host and the table.
// master = requester side, slave = host/table side.
interface hash_table_requester_if #(
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 28
);
  logic                          req_valid_i, req_ready_o;
  logic [1:0]                    req_op_i;
  logic [KEY_WIDTH-1:0]          req_key_i;
  logic [DATA_WIDTH-1:0]         req_data_i;
  logic [2+KEY_WIDTH+DATA_WIDTH-1:0] tbl_data_o;
  logic                          tbl_valid_o, tbl_ready_i;
  logic [4+DATA_WIDTH-1:0]       tbl_data_i;
  logic                          tbl_valid_i, tbl_ready_o;
  logic                          rsp_valid_o, rsp_ready_i;
  logic [1:0]                    rsp_op_o;
  logic [KEY_WIDTH-1:0]          rsp_key_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic [3:0]                    rsp_status_o;
  logic                          rsp_ok_o;

  modport master (
    input  req_valid_i, req_op_i, req_key_i, req_data_i, tbl_ready_i,
           tbl_data_i, tbl_valid_i, rsp_ready_i,
    output req_ready_o, tbl_data_o, tbl_valid_o, tbl_ready_o, rsp_valid_o,
           rsp_op_o, rsp_key_o, rsp_data_o, rsp_status_o, rsp_ok_o
  );
  modport slave (
    output req_valid_i, req_op_i, req_key_i, req_data_i, tbl_ready_i,
           tbl_data_i, tbl_valid_i, rsp_ready_i,
    input  req_ready_o, tbl_data_o, tbl_valid_o, tbl_ready_o, rsp_valid_o,
           rsp_op_o, rsp_key_o, rsp_data_o, rsp_status_o, rsp_ok_o
  );
endinterface

// File: rtl/hash_table_requester.sv
// Forwards host commands to a hash table and pairs in-order responses with a tag FIFO.
// HASH_REQ_TIMEOUT_EN enables a response watchdog driving err_o[2].
module hash_table_requester #(
  parameter int KEY_WIDTH       = 2,
  parameter int DATA_WIDTH      = 28,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
)(
  input  logic                               clk,
  input  logic                               reset,
  hash_table_requester_if.master             bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic [2:0]                         err_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = 2 + KEY_WIDTH + DATA_WIDTH;
  localparam logic [PW:0] FULL_CNT = MAX_OUTSTANDING[PW:0];

  typedef struct packed {
    logic [1:0]           op;
    logic [KEY_WIDTH-1:0] key;
  } tag_t;

  logic                  r_cmd_vld;
  logic [CW-1:0]         r_cmd;
  tag_t                  r_tag [MAX_OUTSTANDING];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  r_rsp_vld;
  tag_t                  r_rsp_tag;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [3:0]            r_rsp_status;
  logic [2:0]            r_err;

  logic w_full, w_empty, w_req_fire, w_push, w_illegal, w_tbl_fire, w_pop, w_stray, w_to_hit;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_req_fire = bus.req_valid_i && bus.req_ready_o;
  assign w_illegal  = w_req_fire && (bus.req_op_i == 2'b11);
  assign w_push     = w_req_fire && (bus.req_op_i != 2'b11);
  assign w_tbl_fire = bus.tbl_valid_i && bus.tbl_ready_o;
  assign w_pop      = w_tbl_fire && !w_empty;
  assign w_stray    = w_tbl_fire && w_empty;

  // Command stage: a new command may enter when the current one leaves this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_vld <= 1'b0;
      r_cmd     <= '0;
    end else if (w_push) begin
      r_cmd_vld <= 1'b1;
      r_cmd     <= {bus.req_op_i, bus.req_key_i, bus.req_data_i};
    end else if (bus.tbl_ready_i) begin
      r_cmd_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wr_ptr] <= '{op: bus.req_op_i, key: bus.req_key_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_vld    <= 1'b0;
      r_rsp_tag    <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
    end else if (w_pop) begin
      r_rsp_vld    <= 1'b1;
      r_rsp_tag    <= r_tag[r_rd_ptr];
      r_rsp_data   <= bus.tbl_data_i[DATA_WIDTH-1:0];
      r_rsp_status <= bus.tbl_data_i[DATA_WIDTH+3:DATA_WIDTH];
    end else if (bus.rsp_ready_i) begin
      r_rsp_vld <= 1'b0;
    end
  end

`ifdef HASH_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt;

  // Counts idle cycles with tags in flight; saturates so the flag stays asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_to_cnt <= '0;
    else if (w_tbl_fire || w_empty) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST)   r_to_cnt <= r_to_cnt + TW'(1);
  end
  assign w_to_hit = !w_tbl_fire && !w_empty && (r_to_cnt == TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= '0;
    else        r_err <= r_err | {w_to_hit, w_stray, w_illegal};
  end

  assign bus.req_ready_o  = (!r_cmd_vld || bus.tbl_ready_i) && !w_full;
  assign bus.tbl_valid_o  = r_cmd_vld;
  assign bus.tbl_data_o   = r_cmd;
  assign bus.tbl_ready_o  = !r_rsp_vld || bus.rsp_ready_i;
  assign bus.rsp_valid_o  = r_rsp_vld;
  assign bus.rsp_op_o     = r_rsp_tag.op;
  assign bus.rsp_key_o    = r_rsp_tag.key;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.rsp_status_o = r_rsp_status;
  assign bus.rsp_ok_o     = (r_rsp_status == 4'h0);
  assign outstanding_o    = r_count;
  assign err_o            = r_err;
endmodule

// File: tb/tb_hash_table_requester.sv
// Scoreboard bench for hash_table_requester: directed scenarios plus random traffic,
// checked against a queue-based model of tags, commands and sticky errors.
module tb_hash_table_requester;
  localparam int KW = 2, DW = 28, MAXO = 4, TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_table_requester_if #(.KEY_WIDTH(KW), .DATA_WIDTH(DW)) bus();
  logic [$clog2(MAXO):0] outstanding;
  logic [2:0]            err;

  hash_table_requester #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
                         .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .outstanding_o(outstanding), .err_o(err));

  typedef struct packed { logic [1:0] op; logic [KW-1:0] key; } tag_t;
  typedef struct packed { logic [1:0] op; logic [KW-1:0] key; logic [DW-1:0] data; logic [3:0] st; } rsp_t;

  logic [2+KW+DW-1:0] exp_cmd[$];
  tag_t               m_tags[$];
  rsp_t               exp_rsp[$];
  logic [2:0]         m_err;
  int                 idle, vectors, miscompares, cmds_seen, rsps_sent;
  logic               h_fire, t_fire;
  bit                 auto_rsp, rnd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Monitor: samples on the falling edge, checks outputs, then advances the model
  // by the transfers that will happen on the coming rising edge.
  task automatic monitor();
    tag_t tg;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cmd.delete(); m_tags.delete(); exp_rsp.delete();
        m_err = '0; idle = 0; h_fire = 1'b0; t_fire = 1'b0;
      end else begin
        h_fire = bus.req_valid_i && bus.req_ready_o;
        t_fire = bus.tbl_valid_i && bus.tbl_ready_o;
        chk("outstanding", 64'(outstanding), 64'(m_tags.size()));
        chk("err", 64'(err), 64'(m_err));
        if (m_tags.size() == MAXO) chk("req_ready_full", 64'(bus.req_ready_o), 64'(0));
        if (bus.tbl_valid_o && bus.tbl_ready_i) begin
          cmds_seen++;
          if (exp_cmd.size() == 0) fail("tbl_cmd", "command seen, none expected");
          else chk("tbl_cmd", 64'(bus.tbl_data_o), 64'(exp_cmd.pop_front()));
        end
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
          if (exp_rsp.size() == 0) fail("rsp", "response seen, none expected");
          else begin
            r = exp_rsp.pop_front();
            chk("rsp", 64'({bus.rsp_op_o, bus.rsp_key_o, bus.rsp_data_o, bus.rsp_status_o}), 64'(r));
            chk("rsp_ok", 64'(bus.rsp_ok_o), 64'(r.st == 4'h0));
          end
        end
`ifdef HASH_REQ_TIMEOUT_EN
        if (m_tags.size() != 0 && !t_fire) begin
          idle++;
          if (idle >= TO) m_err[2] = 1'b1;
        end else idle = 0;
`endif
        if (t_fire) begin
          if (m_tags.size() == 0) m_err[1] = 1'b1;
          else begin
            tg = m_tags.pop_front();
            exp_rsp.push_back({tg.op, tg.key, bus.tbl_data_i[DW-1:0], bus.tbl_data_i[DW+3:DW]});
          end
        end
        if (h_fire) begin
          if (bus.req_op_i == 2'b11) m_err[0] = 1'b1;
          else begin
            exp_cmd.push_back({bus.req_op_i, bus.req_key_i, bus.req_data_i});
            m_tags.push_back({bus.req_op_i, bus.req_key_i});
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (h_fire) bus.req_valid_i = 1'b0;
    if (t_fire) bus.tbl_valid_i = 1'b0;
    if (auto_rsp && !bus.tbl_valid_i && cmds_seen > rsps_sent && $urandom_range(2) != 0) begin
      bus.tbl_data_i  = {($urandom_range(3) == 0) ? 4'($urandom) : 4'h0, DW'($urandom)};
      bus.tbl_valid_i = 1'b1;
      rsps_sent++;
    end
    if (rnd) begin
      bus.tbl_ready_i = ($urandom_range(3) != 0);
      bus.rsp_ready_i = ($urandom_range(3) != 0);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int key, input int data);
    bus.req_op_i = op; bus.req_key_i = KW'(key); bus.req_data_i = DW'(data);
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 50 && bus.req_valid_i; i++) step();
    if (bus.req_valid_i) begin fail("cmd_accept", "command not accepted in 50 cycles"); bus.req_valid_i = 1'b0; end
  endtask

  task automatic send_rsp(input int data, input logic [3:0] st, input bit counted);
    bus.tbl_data_i = {st, DW'(data)}; bus.tbl_valid_i = 1'b1;
    if (counted) rsps_sent++;
    for (int i = 0; i < 50 && bus.tbl_valid_i; i++) step();
    if (bus.tbl_valid_i) begin fail("rsp_accept", "response not accepted in 50 cycles"); bus.tbl_valid_i = 1'b0; end
  endtask

  task automatic drain();
    int i;
    rnd = 1'b0; bus.tbl_ready_i = 1'b1; bus.rsp_ready_i = 1'b1; auto_rsp = 1'b1;
    for (i = 0; i < 500 && (m_tags.size() != 0 || exp_rsp.size() != 0 || bus.req_valid_i
                            || bus.tbl_valid_i || bus.rsp_valid_o); i++) step();
    if (i == 500) fail("drain", "traffic still pending after 500 cycles, required empty");
    auto_rsp = 1'b0;
  endtask

  initial begin
    bus.req_valid_i = 0; bus.req_op_i = 0; bus.req_key_i = 0; bus.req_data_i = 0;
    bus.tbl_ready_i = 1; bus.tbl_data_i = 0; bus.tbl_valid_i = 0; bus.rsp_ready_i = 1;
    vectors = 0; miscompares = 0; cmds_seen = 0; rsps_sent = 0; m_err = 0; idle = 0;
    h_fire = 0; t_fire = 0; auto_rsp = 0; rnd = 0;
    fork monitor(); join_none

    repeat (3) @(posedge clk); #1;
    chk("rst_tbl_valid", 64'(bus.tbl_valid_o), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'(1));
    chk("rst_tbl_ready", 64'(bus.tbl_ready_o), 64'(1));
    rst_n = 1'b1;
    step();

    // Single write with clean status
    send_cmd(2'b01, 1, 5);
    chk("write_cmd_word", 64'(bus.tbl_data_o), 64'({2'b01, 2'd1, 28'h5}));
    send_rsp(0, 4'h0, 1'b1);
    chk("write_rsp_op", 64'(bus.rsp_op_o), 64'(2'b01));
    chk("write_rsp_key", 64'(bus.rsp_key_o), 64'(1));
    chk("write_rsp_ok", 64'(bus.rsp_ok_o), 64'(1));
    drain();

    // Tag FIFO full backpressure
    for (int k = 0; k < 4; k++) send_cmd(2'b00, k, 0);
    bus.req_op_i = 2'b00; bus.req_key_i = 2'd0; bus.req_valid_i = 1'b1;
    repeat (3) step();
    chk("full_outstanding", 64'(outstanding), 64'(4));
    chk("full_req_ready", 64'(bus.req_ready_o), 64'(0));
    chk("full_pending", 64'(bus.req_valid_i), 64'(1));
    send_rsp(32'h77, 4'h0, 1'b1);
    chk("pop_outstanding", 64'(outstanding), 64'(3));
    chk("pop_req_ready", 64'(bus.req_ready_o), 64'(1));
    drain();

    // In-order pairing of reads
    for (int k = 0; k < 3; k++) send_cmd(2'b00, k, 0);
    for (int i = 0; i < 20 && cmds_seen < rsps_sent + 3; i++) step();
    send_rsp(32'hA, 4'h0, 1'b1);
    send_rsp(32'hB, 4'h4, 1'b1);
    send_rsp(32'hC, 4'h0, 1'b1);
    drain();

    // Stray response, then illegal op
    send_rsp(32'h3, 4'h0, 1'b0);
    step(); step();
    chk("stray_err", 64'(err), 64'(3'b010));
    chk("stray_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
    send_cmd(2'b11, 2, 9);
    for (int i = 0; i < 3; i++) begin
      chk("illegal_no_fwd", 64'(bus.tbl_valid_o), 64'(0));
      step();
    end
    chk("illegal_err", 64'(err), 64'(3'b011));

    // Randomized traffic with random backpressure
    rnd = 1'b1; auto_rsp = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!bus.req_valid_i && $urandom_range(2) != 0) begin
        bus.req_op_i    = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
        bus.req_key_i   = KW'($urandom);
        bus.req_data_i  = DW'($urandom);
        bus.req_valid_i = 1'b1;
      end
    end
    drain();

    // Unanswered read: watchdog
    send_cmd(2'b00, 3, 0);
    repeat (TO + 4) step();
`ifdef HASH_REQ_TIMEOUT_EN
    chk("timeout_err2", 64'(err[2]), 64'(1));
`else
    chk("timeout_err2", 64'(err[2]), 64'(0));
`endif

    // Asynchronous reset with traffic in flight
    for (int k = 0; k < 3; k++) send_cmd(2'b00, k, 0);
    bus.rsp_ready_i = 1'b0;
    send_rsp(32'h55, 4'h0, 1'b1);
    step();
    chk("pre_rst_outstanding", 64'(outstanding), 64'(3));
    chk("pre_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(1));
    #2 rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.tbl_valid_i = 1'b0;
    #1;
    chk("arst_tbl_valid", 64'(bus.tbl_valid_o), 64'(0));
    chk("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("arst_outstanding", 64'(outstanding), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_req_ready", 64'(bus.req_ready_o), 64'(1));
    chk("arst_tbl_ready", 64'(bus.tbl_ready_o), 64'(1));
    chk("arst_tbl_data", 64'(bus.tbl_data_o), 64'(0));
    chk("arst_rsp_data", 64'({bus.rsp_op_o, bus.rsp_key_o, bus.rsp_data_o, bus.rsp_status_o}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rsps_sent = cmds_seen;
    rst_n = 1'b1;
    step();
    send_cmd(2'b10, 2, 7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hash_table_requester.md
HASH_TABLE_REQUESTER -- requirements
Module: hash_table_requester

Interface
REQ-001 Parameter KEY_WIDTH, default 2, key bits per command.
REQ-002 Parameter DATA_WIDTH, default 28, data bits per command/response.
REQ-003 Parameter MAX_OUTSTANDING, default 4, tag FIFO depth; power of two, >=2.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with macro, REQ-032).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid_i / req_ready_o  input/output  1/1  host command handshake.
REQ-008 req_op_i  input  2  00 read, 01 write, 10 delete, 11 illegal.
REQ-009 req_key_i / req_data_i  input  KEY_WIDTH/DATA_WIDTH  command key and data.
REQ-010 tbl_data_o  output  2+KEY_WIDTH+DATA_WIDTH  command word {op, key, data}, op in MSBs, data in LSBs.
REQ-011 tbl_valid_o / tbl_ready_i  output/input  1/1  command handshake toward table.
REQ-012 tbl_data_i  input  4+DATA_WIDTH  response word; [DATA_WIDTH-1:0] read data; bit DATA_WIDTH+0 no_deletion_target, +1 no_write_space, +2 no_element_found, +3 key_already_present.
REQ-013 tbl_valid_i / tbl_ready_o  input/output  1/1  response handshake from table.
REQ-014 rsp_valid_o / rsp_ready_i  output/input  1/1  host response handshake.
REQ-015 rsp_op_o / rsp_key_o / rsp_data_o / rsp_status_o  output  2/KEY_WIDTH/DATA_WIDTH/4  echoed op, echoed key, read data, four status flags.
REQ-016 rsp_ok_o  output  1  high when rsp_status_o == 0.
REQ-017 outstanding_o  output  clog2(MAX_OUTSTANDING)+1  tags in flight.
REQ-018 err_o  output  3  sticky: bit0 illegal op, bit1 unexpected response, bit2 timeout.

Function
REQ-019 Transfer occurs on a cycle where valid and ready are both high; valid, once high, holds with stable payload until accepted.
REQ-020 Command stage is a one-entry register; req_ready_o = (stage empty OR tbl_ready_i) AND tag FIFO not full.
REQ-021 Accepted legal command loads the stage and pushes {op,key} to the tag FIFO in the same cycle; tbl_valid_o rises the next cycle (latency 1).
REQ-022 Accepted op 11 is consumed, not forwarded, not tagged, and sets err_o[0].
REQ-023 Response stage is a one-entry register; tbl_ready_o = response stage empty OR rsp_ready_i.
REQ-024 Accepted response with FIFO non-empty pops the oldest tag and registers {tag op, tag key, data, status}; rsp_valid_o rises next cycle.
REQ-025 Accepted response with FIFO empty is discarded and sets err_o[1]; no rsp_valid_o.
REQ-026 Responses return in command order; no reordering.
REQ-027 Push and pop in the same cycle leave outstanding_o unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-028 At outstanding_o == MAX_OUTSTANDING, req_ready_o is low regardless of tbl_ready_i.
REQ-029 err_o bits clear only on reset.

Reset
REQ-030 reset low asynchronously forces tbl_valid_o=0, rsp_valid_o=0, outstanding_o=0, err_o=0, FIFO pointers=0, tbl_data_o=0, rsp_* data=0; req_ready_o=1 and tbl_ready_o=1 after reset.
REQ-031 Reset mid-operation drops all in-flight commands and tags; the table is reset by the same signal.

Configuration
REQ-032 Macro HASH_REQ_TIMEOUT_EN defined: a counter increments each cycle with outstanding_o>0 and no response accepted, clears on response accept or outstanding_o==0; reaching TIMEOUT_CYCLES sets err_o[2].
REQ-033 Macro undefined: no counter exists; err_o[2] is constant 0.

Verification
REQ-034 Write key 1 data 0x5, table returns status 0 -> tbl_data_o = {01,1,0x5}; rsp_op_o=01, rsp_key_o=1, rsp_ok_o=1.
REQ-035 Issue 5 reads with tbl_ready_i=1, no responses -> 4 accepted, req_ready_o low, outstanding_o=4; one response -> outstanding_o=3, req_ready_o high.
REQ-036 Reads keys 0,1,2 with responses 0xA, 0xB, 0xC -> host sees keys 0,1,2 paired with 0xA,0xB,0xC in order.
REQ-037 Response with FIFO empty -> err_o=3'b010, no rsp_valid_o; op 11 -> err_o[0]=1, tbl_valid_o stays 0.
REQ-038 Macro defined, TIMEOUT_CYCLES=16, one read never answered -> err_o[2]=1 after 16 cycles; macro undefined -> err_o[2]=0.
REQ-039 reset low while outstanding_o=3 and rsp_valid_o=1 -> all outputs at reset values immediately, before next clk edge.
